// File: rtl/input_repeater.sv
// input_repeater: per-channel synchroniser, debouncer and command-pulse
// generator (off / one-shot / DAS / fixed-rate repeat), with optional
// last-pressed-wins arbitration between channels 0 and 1.
module input_repeater #(
  parameter int N_CH      = 7,
  parameter int TW        = 6,
  parameter int DB_CYCLES = 4,
  parameter int OPP_EN    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_game,
  input  logic [N_CH-1:0]     raw_i,
  input  logic [2*N_CH-1:0]   mode_i,
  input  logic [TW-1:0]       das_delay_i,
  input  logic [TW-1:0]       das_speed_i,
  output logic [N_CH-1:0]     cmd_o,
  output logic [N_CH-1:0]     held_o
);

  // Debounce counter must hold DB_CYCLES; keep at least one bit when DB_CYCLES is 0.
  localparam int CW  = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int TW1 = TW + 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_DAS    = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

  logic [N_CH-1:0]          s1_q, s1_d, s2_q, s2_d;
  logic [N_CH-1:0]          lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic [N_CH-1:0][CW-1:0]  db_cnt_q, db_cnt_d;
  logic [N_CH-1:0][TW-1:0]  timer_q, timer_d;
  logic [N_CH-1:0]          phase_q, phase_d;
  logic [N_CH-1:0]          cmd_q, cmd_d;
  logic [2*N_CH-1:0]        mode_prev_q, mode_prev_d;
  logic                     last_q, last_d;

  logic [N_CH-1:0]          press_s;
  logic [N_CH-1:0]          sup_s;
  logic [TW1-1:0]           delay_s, speed_s;

  assign cmd_o  = cmd_q;
  assign held_o = lvl_q;

  // Two-flop synchroniser and per-channel debounce of the synchronised level.
  always_comb begin
    s1_d       = raw_i;
    s2_d       = s1_q;
    lvl_d      = lvl_q;
    lvl_prev_d = lvl_q;
    db_cnt_d   = db_cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          lvl_d[i]    = s2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Press edges and effective periods (a zero period behaves as one tick).
  always_comb begin
    press_s = lvl_q & ~lvl_prev_q;
    if (das_delay_i == '0) begin
      delay_s = TW1'(1);
    end else begin
      delay_s = {1'b0, das_delay_i};
    end
    if (das_speed_i == '0) begin
      speed_s = TW1'(1);
    end else begin
      speed_s = {1'b0, das_speed_i};
    end
  end

  // Opposing-pair arbitration: the newest press of ch0/ch1 wins, ch1 on a tie.
  always_comb begin
    last_d = last_q;
    sup_s  = '0;
    if (OPP_EN != 0) begin
      if (press_s[1]) begin
        last_d = 1'b1;
      end else if (press_s[0]) begin
        last_d = 1'b0;
      end else begin
        last_d = last_q;
      end
      if (lvl_q[0] && lvl_q[1]) begin
        sup_s[0] = last_d;
        sup_s[1] = ~last_d;
      end else begin
        sup_s = '0;
      end
    end else begin
      last_d = 1'b0;
    end
  end

  // Per-channel repeat engine: press pulse, then tick-driven delay/repeat pulses.
  always_comb begin : rep_engine
    logic [1:0]     mode_v;
    logic [TW1-1:0] period_v;
    logic [TW1-1:0] next_v;
    cmd_d       = '0;
    timer_d     = timer_q;
    phase_d     = phase_q;
    mode_prev_d = mode_i;
    mode_v      = MODE_OFF;
    period_v    = '0;
    next_v      = '0;
    for (int i = 0; i < N_CH; i++) begin
      mode_v = mode_i[2*i +: 2];
      if ((mode_v == MODE_DAS) && !phase_q[i]) begin
        period_v = delay_s;
      end else begin
        period_v = speed_s;
      end
      next_v = {1'b0, timer_q[i]} + TW1'(1);
      if ((mode_v == MODE_OFF) || sup_s[i]) begin
        timer_d[i] = '0;
        phase_d[i] = 1'b0;
      end else if (press_s[i]) begin
        cmd_d[i]   = 1'b1;
        timer_d[i] = '0;
        phase_d[i] = 1'b0;
      end else if (!lvl_q[i] || (mode_v != mode_prev_q[2*i +: 2])) begin
        timer_d[i] = '0;
        phase_d[i] = 1'b0;
      end else if (tick_game) begin
        case (mode_v)
          MODE_DAS, MODE_REPEAT: begin
            if (next_v >= period_v) begin
              cmd_d[i]   = 1'b1;
              timer_d[i] = '0;
              phase_d[i] = 1'b1;
            end else begin
              timer_d[i] = next_v[TW-1:0];
            end
          end
          MODE_ONESHOT: begin
            timer_d[i] = '0;
            phase_d[i] = 1'b0;
          end
          default: begin
            timer_d[i] = '0;
            phase_d[i] = 1'b0;
          end
        endcase
      end else begin
        timer_d[i] = timer_q[i];
        phase_d[i] = phase_q[i];
      end
    end
  end

  // State registers; reset clears everything so a held button re-presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      lvl_q       <= '0;
      lvl_prev_q  <= '0;
      db_cnt_q    <= '0;
      timer_q     <= '0;
      phase_q     <= '0;
      cmd_q       <= '0;
      mode_prev_q <= '0;
      last_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      lvl_q       <= lvl_d;
      lvl_prev_q  <= lvl_prev_d;
      db_cnt_q    <= db_cnt_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      cmd_q       <= cmd_d;
      mode_prev_q <= mode_prev_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_input_repeater.sv
// Directed bench for input_repeater with hand-derived pulse schedules.
module tb_input_repeater;
  localparam int N_CH = 7;
  localparam int TW   = 6;
  localparam int DB   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                tick_game;
  logic [N_CH-1:0]     raw_i;
  logic [2*N_CH-1:0]   mode_i;
  logic [TW-1:0]       das_delay_i;
  logic [TW-1:0]       das_speed_i;
  logic [N_CH-1:0]     cmd_o;
  logic [N_CH-1:0]     held_o;

  int checks = 0;
  int errors = 0;
  int pcnt [N_CH];
  int dbl = 0;
  logic [N_CH-1:0] cmd_prev = '0;

  input_repeater #(.N_CH(N_CH), .TW(TW), .DB_CYCLES(DB), .OPP_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick_game(tick_game), .raw_i(raw_i),
    .mode_i(mode_i), .das_delay_i(das_delay_i), .das_speed_i(das_speed_i),
    .cmd_o(cmd_o), .held_o(held_o)
  );

  always #5 clk = ~clk;

  // Pulse counters per channel and back-to-back pulse detector.
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (cmd_o[i]) pcnt[i] <= pcnt[i] + 1;
    end
    if ((cmd_o & cmd_prev) != '0) dbl <= dbl + 1;
    cmd_prev <= cmd_o;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk) tick_game = 1'b1;
    @(negedge clk) tick_game = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode_i[2*ch +: 2] = m;
  endtask

  initial begin
    int c, c1, bad, exp;
    rst_n = 1'b1; tick_game = 1'b0; raw_i = '0; mode_i = '0;
    das_delay_i = 6'd16; das_speed_i = 6'd6;
    #2 rst_n = 1'b0;
    cyc(3);
    check("rst_cmd", int'(cmd_o), 0);
    check("rst_held", int'(held_o), 0);
    @(negedge clk) rst_n = 1'b1;
    cyc(3);

    // DAS 16/6 on ch0 for 40 ticks
    set_mode(0, 2'b10); cyc(2);
    c = pcnt[0]; raw_i[0] = 1'b1; cyc(12);
    check("das_press", pcnt[0] - c, 1);
    check("das_held", int'(held_o[0]), 1);
    for (int t = 1; t <= 40; t++) begin
      c1 = pcnt[0];
      do_tick();
      exp = (t == 16 || t == 22 || t == 28 || t == 34 || t == 40) ? 1 : 0;
      check($sformatf("das_t%0d", t), pcnt[0] - c1, exp);
    end
    check("das_total", pcnt[0] - c, 6);
    raw_i[0] = 1'b0; c = pcnt[0]; cyc(10);
    repeat (10) do_tick();
    check("das_release", pcnt[0] - c, 0);
    check("das_held_rel", int'(held_o[0]), 0);

    // Debounce on ch2: bouncing rejected, clean rise gives one pulse
    set_mode(2, 2'b10); cyc(2);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      raw_i[2] = ~raw_i[2];
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (held_o[2]) bad++;
      end
    end
    check("bounce_held", bad, 0);
    c = pcnt[2]; raw_i[2] = 1'b1; bad = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (cmd_o[2]) bad++;
    end
    check("db_early", bad, 0);
    @(negedge clk);
    check("db_edge", int'(cmd_o[2]), 1);
    cyc(10);
    check("db_count", pcnt[2] - c, 1);
    raw_i[2] = 1'b0; cyc(12);

    // ONESHOT on ch4, press coincident with a tick
    set_mode(4, 2'b01); cyc(2);
    c = pcnt[4]; raw_i[4] = 1'b1;
    cyc(7); tick_game = 1'b1;
    @(negedge clk) tick_game = 1'b0;
    check("oneshot_press", int'(cmd_o[4]), 1);
    repeat (100) do_tick();
    check("oneshot_total", pcnt[4] - c, 1);
    raw_i[4] = 1'b0; cyc(12);

    // Opposing pair ch0/ch1, DAS 16/6
    set_mode(1, 2'b10); cyc(2);
    c = pcnt[0]; raw_i[0] = 1'b1; cyc(12);
    check("opp_p0", pcnt[0] - c, 1);
    repeat (5) do_tick();
    c = pcnt[0]; c1 = pcnt[1]; raw_i[1] = 1'b1; cyc(12);
    check("opp_p1", pcnt[1] - c1, 1);
    check("opp_p0_quiet", pcnt[0] - c, 0);
    c1 = pcnt[1];
    repeat (25) do_tick();
    check("opp_ch0_silent", pcnt[0] - c, 0);
    check("opp_ch1_rep", pcnt[1] - c1, 2);
    raw_i[1] = 1'b0; cyc(12);
    c1 = pcnt[1];
    for (int t = 31; t <= 58; t++) begin
      c = pcnt[0];
      do_tick();
      exp = (t == 46 || t == 52 || t == 58) ? 1 : 0;
      check($sformatf("opp_t%0d", t), pcnt[0] - c, exp);
    end
    check("opp_ch1_after", pcnt[1] - c1, 0);
    raw_i[0] = 1'b0; cyc(12);

    // REPEAT speed 3 on ch2 with an OFF interval
    das_speed_i = 6'd3; set_mode(2, 2'b11); cyc(2);
    c = pcnt[2]; raw_i[2] = 1'b1; cyc(12);
    check("rep_press", pcnt[2] - c, 1);
    c = pcnt[2];
    repeat (6) do_tick();
    check("rep_six", pcnt[2] - c, 2);
    set_mode(2, 2'b00); c = pcnt[2];
    repeat (5) do_tick();
    check("rep_off", pcnt[2] - c, 0);
    check("rep_off_held", int'(held_o[2]), 1);
    set_mode(2, 2'b11); cyc(2);
    for (int t = 1; t <= 3; t++) begin
      c = pcnt[2];
      do_tick();
      check($sformatf("rep_back_t%0d", t), pcnt[2] - c, (t == 3) ? 1 : 0);
    end
    raw_i[2] = 1'b0; cyc(12);

    // Asynchronous reset mid-repeat with ch0 held
    set_mode(0, 2'b11); cyc(2);
    raw_i[0] = 1'b1; cyc(12);
    repeat (2) do_tick();
    @(negedge clk) tick_game = 1'b1;
    @(negedge clk) tick_game = 1'b0;
    check("pre_rst_cmd", int'(cmd_o[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_cmd", int'(cmd_o), 0);
    check("async_held", int'(held_o), 0);
    cyc(3);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (cmd_o[0]) bad++;
    end
    check("post_rst_early", bad, 0);
    @(negedge clk);
    check("post_rst_press", int'(cmd_o[0]), 1);
    check("post_rst_held", int'(held_o[0]), 1);
    raw_i[0] = 1'b0; cyc(12);

    check("no_double_pulse", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
